fp_move_box_unit: RTL and testbench

- Pipelined FALU move/classify unit for the transfers that produce and consume NaN-boxed values.
- Int->FP moves (FMV.W.X, FMV.D.X) write NaN-boxed singles, i.e. it is the boxing writer for the FP register file. FP->int moves (FMV.X.W, FMV.X.D) and FCLASS read FP sources.
- Sits beside the sign-injection unit in FALU, with a valid/ready handshake to dispatch and writeback, and a ROB tag carried through.

---
 rtl/fp_move_box_unit_pkg.sv | 18 +
 rtl/fp_move_box_unit_classify.sv | 31 +++
 rtl/fp_move_box_unit.sv | 97 +++++++++
 tb/tb_fp_move_box_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fp_move_box_unit_pkg.sv
// fp_move_box_unit_pkg: shared FALU op codes, canonical NaNs and FCLASS bit positions.
package fp_move_box_unit_pkg;
  localparam logic [1:0] OP_FMV_X = 2'b00;
  localparam logic [1:0] OP_FMV_F = 2'b01;
  localparam logic [1:0] OP_FCLASS = 2'b10;
  localparam logic [63:0] CANON_QNAN_S = 64'hFFFFFFFF7FC00000;
  localparam logic [63:0] CANON_QNAN_D = 64'h7FF8000000000000;
  localparam int CLS_NEG_INF = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF = 7;
  localparam int CLS_SNAN = 8;
  localparam int CLS_QNAN = 9;
endpackage

// File: rtl/fp_move_box_unit_classify.sv
// fp_classify: one-hot FCLASS of a single or double; unboxed singles classify as canonical qNaN.
module fp_classify
  import fp_move_box_unit_pkg::*;
(
  input  logic [63:0] val_i,
  input  logic        dbl_i,
  output logic [9:0]  cls_o
);
  logic [31:0] s;
  logic sgn, e_max, e_zero, m_zero, quiet, norm;
  always_comb begin
    s = &val_i[63:32] ? val_i[31:0] : CANON_QNAN_S[31:0];
    sgn = dbl_i ? val_i[63] : s[31];
    e_max = dbl_i ? &val_i[62:52] : &s[30:23];
    e_zero = dbl_i ? ~|val_i[62:52] : ~|s[30:23];
    m_zero = dbl_i ? ~|val_i[51:0] : ~|s[22:0];
    quiet = dbl_i ? val_i[51] : s[22];
    norm = ~e_max & ~e_zero;
    cls_o = '0;
    cls_o[CLS_NEG_INF] = sgn & e_max & m_zero;
    cls_o[CLS_NEG_NORM] = sgn & norm;
    cls_o[CLS_NEG_SUB] = sgn & e_zero & ~m_zero;
    cls_o[CLS_NEG_ZERO] = sgn & e_zero & m_zero;
    cls_o[CLS_POS_ZERO] = ~sgn & e_zero & m_zero;
    cls_o[CLS_POS_SUB] = ~sgn & e_zero & ~m_zero;
    cls_o[CLS_POS_NORM] = ~sgn & norm;
    cls_o[CLS_POS_INF] = ~sgn & e_max & m_zero;
    cls_o[CLS_SNAN] = e_max & ~m_zero & ~quiet;
    cls_o[CLS_QNAN] = e_max & ~m_zero & quiet;
  end
endmodule

// File: rtl/fp_move_box_unit.sv
// fp_move_box_unit: FMV.X/FMV.F/FCLASS with 1-cycle latency, output register plus one skid entry.
module fp_move_box_unit
  import fp_move_box_unit_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       IN_OP,
  input  logic             IN_DOUBLE,
  input  logic [63:0]      IN_SRC,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [63:0]      OUT_DATA,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_TO_FPR
);
  logic [9:0] cls;
  logic [63:0] res_data;
  logic res_fpr, accept, drain;
  logic out_valid_q, out_valid_d, out_fpr_q, out_fpr_d;
  logic [63:0] out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic skid_valid_q, skid_valid_d, skid_fpr_q, skid_fpr_d;
  logic [63:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  fp_classify u_classify (.val_i(IN_SRC), .dbl_i(IN_DOUBLE), .cls_o(cls));
  always_comb begin
    res_data = IN_OP == OP_FMV_F ? (IN_DOUBLE ? IN_SRC : {32'hFFFFFFFF, IN_SRC[31:0]}) :
               IN_OP == OP_FMV_X ? (IN_DOUBLE ? IN_SRC : {{32{IN_SRC[31]}}, IN_SRC[31:0]}) :
               IN_OP == OP_FCLASS ? {54'b0, cls} : 64'b0;
    res_fpr = IN_OP == OP_FMV_F;
    accept = IN_VALID & ~skid_valid_q;
    drain = out_valid_q & OUT_READY;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_tag_d = out_tag_q;
    out_fpr_d = out_fpr_q;
    skid_valid_d = skid_valid_q;
    skid_data_d = skid_data_q;
    skid_tag_d = skid_tag_q;
    skid_fpr_d = skid_fpr_q;
    if (FLUSH) begin
      out_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        out_data_d = skid_data_q;
        out_tag_d = skid_tag_q;
        out_fpr_d = skid_fpr_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept && (!out_valid_q || drain)) begin
      out_valid_d = 1'b1;
      out_data_d = res_data;
      out_tag_d = IN_TAG;
      out_fpr_d = res_fpr;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d = res_data;
      skid_tag_d = IN_TAG;
      skid_fpr_d = res_fpr;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q <= '0;
      out_fpr_q <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q <= '0;
      skid_fpr_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_tag_q <= out_tag_d;
      out_fpr_q <= out_fpr_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q <= skid_data_d;
      skid_tag_q <= skid_tag_d;
      skid_fpr_q <= skid_fpr_d;
    end
  end
  assign IN_READY = ~skid_valid_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA = out_data_q;
  assign OUT_TAG = out_tag_q;
  assign OUT_TO_FPR = out_fpr_q;
endmodule

// File: tb/tb_fp_move_box_unit.sv
// tb_fp_move_box_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fp_move_box_unit;
  import fp_move_box_unit_pkg::*;
  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  tag;
    logic        fpr;
  } exp_t;
  logic CLK = 0, RST = 0, FLUSH = 0, IN_VALID = 0, IN_DOUBLE = 0, OUT_READY = 0;
  logic IN_READY, OUT_VALID, OUT_TO_FPR;
  logic [1:0] IN_OP = 0;
  logic [63:0] IN_SRC = 0, OUT_DATA;
  logic [5:0] IN_TAG = 0, OUT_TAG;
  int n_cmp = 0, n_err = 0;
  exp_t q[$];
  always #5 CLK = ~CLK;
  fp_move_box_unit #(.TAG_W(6)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OP(IN_OP), .IN_DOUBLE(IN_DOUBLE), .IN_SRC(IN_SRC), .IN_TAG(IN_TAG),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_TAG(OUT_TAG), .OUT_TO_FPR(OUT_TO_FPR));
  function automatic logic [9:0] ref_class(input logic dbl, input logic [63:0] v_in);
    logic [63:0] v;
    int e, emax, idx;
    logic sgn, qbit, mz;
    v = (!dbl && v_in[63:32] != 32'hFFFFFFFF) ? 64'hFFFFFFFF7FC00000 : v_in;
    if (dbl) begin
      sgn = v[63]; e = int'(v[62:52]); emax = 2047; mz = v[51:0] == 0; qbit = v[51];
    end else begin
      sgn = v[31]; e = int'(v[30:23]); emax = 255; mz = v[22:0] == 0; qbit = v[22];
    end
    if (e == emax) idx = mz ? (sgn ? 0 : 7) : (qbit ? 9 : 8);
    else if (e == 0) idx = mz ? (sgn ? 3 : 4) : (sgn ? 2 : 5);
    else idx = sgn ? 1 : 6;
    return 10'd1 << idx;
  endfunction
  function automatic exp_t ref_result(input logic [1:0] op, input logic dbl, input logic [63:0] src, input logic [5:0] tag);
    exp_t r;
    r.tag = tag;
    r.fpr = op == OP_FMV_F;
    if (op == OP_FMV_F) r.data = dbl ? src : {32'hFFFFFFFF, src[31:0]};
    else if (op == OP_FMV_X) r.data = dbl ? src : 64'($signed(src[31:0]));
    else if (op == OP_FCLASS) r.data = {54'b0, ref_class(dbl, src)};
    else r.data = 64'b0;
    return r;
  endfunction
  task automatic drive(input logic v, input logic [1:0] op, input logic dbl, input logic [63:0] src,
                       input logic [5:0] tag, input logic ordy, input logic fl, input logic rst);
    bit acc;
    IN_VALID = v; IN_OP = op; IN_DOUBLE = dbl; IN_SRC = src; IN_TAG = tag;
    OUT_READY = ordy; FLUSH = fl; RST = rst;
    @(posedge CLK);
    acc = v && q.size() < 2;
    if (rst || fl) q.delete();
    else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(ref_result(op, dbl, src, tag));
    end
    @(negedge CLK);
  endtask
  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", OUT_VALID); end
    n_cmp++; if (OUT_DATA !== 64'h0) begin n_err++; $display("FAIL reset_data got %h want 0", OUT_DATA); end
    n_cmp++; if (OUT_TAG !== 6'h0) begin n_err++; $display("FAIL reset_tag got %0d want 0", OUT_TAG); end
    n_cmp++; if (OUT_TO_FPR !== 1'b0) begin n_err++; $display("FAIL reset_fpr got %b want 0", OUT_TO_FPR); end
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", IN_READY); end
  endtask
  task automatic test_ops();
    logic [1:0] ops[10] = '{OP_FMV_F, OP_FMV_X, OP_FMV_X, OP_FMV_F, OP_FMV_F, OP_FCLASS, OP_FCLASS, OP_FCLASS, OP_FCLASS, 2'b11};
    logic dbls[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 0};
    logic [63:0] srcs[10] = '{64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 64'h1234_5678_3F80_0000,
                              64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF_0000_0001, 64'h0, 64'hFFFF_FFFF_FF80_0000,
                              64'h7FF0_0000_0000_0001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] exps[10] = '{64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 64'h0000_0000_3F80_0000,
                              64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0001, 64'h200, 64'h001,
                              64'h100, 64'h008, 64'h0};
    logic fprs[10] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      drive(1, ops[i], dbls[i], srcs[i], 6'(i + 5), 1, 0, 0);
      n_cmp++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL op%0d_valid got %b want 1", i, OUT_VALID); end
      n_cmp++; if (OUT_DATA !== exps[i]) begin n_err++; $display("FAIL op%0d_data got %h want %h", i, OUT_DATA, exps[i]); end
      n_cmp++; if (OUT_TO_FPR !== fprs[i]) begin n_err++; $display("FAIL op%0d_fpr got %b want %b", i, OUT_TO_FPR, fprs[i]); end
      n_cmp++; if (OUT_TAG !== 6'(i + 5)) begin n_err++; $display("FAIL op%0d_tag got %0d want %0d", i, OUT_TAG, i + 5); end
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL ops_drain got %b want 0", OUT_VALID); end
  endtask
  task automatic test_back_to_back();
    drive(1, OP_FMV_X, 1, 64'hA1, 1, 0, 0, 0);
    n_cmp++; if (OUT_TAG !== 6'd1 || IN_READY !== 1'b1) begin n_err++; $display("FAIL b2b_1 got tag %0d ready %b want 1 1", OUT_TAG, IN_READY); end
    drive(1, OP_FMV_X, 1, 64'hA2, 2, 0, 0, 0);
    n_cmp++; if (OUT_TAG !== 6'd1 || IN_READY !== 1'b0) begin n_err++; $display("FAIL b2b_2 got tag %0d ready %b want 1 0", OUT_TAG, IN_READY); end
    drive(1, OP_FMV_X, 1, 64'hA3, 3, 0, 0, 0);
    n_cmp++; if (OUT_DATA !== 64'hA1 || IN_READY !== 1'b0) begin n_err++; $display("FAIL b2b_stall got data %h ready %b want a1 0", OUT_DATA, IN_READY); end
    drive(1, OP_FMV_X, 1, 64'hA3, 3, 1, 0, 0);
    n_cmp++; if (OUT_TAG !== 6'd2 || OUT_DATA !== 64'hA2 || IN_READY !== 1'b1) begin n_err++; $display("FAIL b2b_skid got tag %0d data %h ready %b want 2 a2 1", OUT_TAG, OUT_DATA, IN_READY); end
    drive(1, OP_FMV_X, 1, 64'hA3, 3, 1, 0, 0);
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_TAG !== 6'd3) begin n_err++; $display("FAIL b2b_3 got valid %b tag %0d want 1 3", OUT_VALID, OUT_TAG); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b want 0", OUT_VALID); end
  endtask
  task automatic test_flush();
    drive(1, OP_FMV_X, 1, 64'hB0, 10, 0, 0, 0);
    drive(1, OP_FMV_X, 1, 64'hB1, 11, 0, 0, 0);
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL flush_full got ready %b want 0", IN_READY); end
    drive(1, OP_FMV_X, 1, 64'hB2, 12, 0, 1, 0);
    n_cmp++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin n_err++; $display("FAIL flush got valid %b ready %b want 0 1", OUT_VALID, IN_READY); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL flush_ghost%0d got valid %b tag %0d want 0", i, OUT_VALID, OUT_TAG); end
    end
  endtask
  task automatic test_reset_mid_stall();
    drive(1, OP_FMV_F, 0, 64'h1, 20, 0, 0, 0);
    drive(1, OP_FMV_F, 0, 64'h2, 21, 0, 0, 0);
    drive(1, OP_FMV_F, 0, 64'h3, 22, 0, 0, 1);
    n_cmp++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 64'h0 || OUT_TAG !== 6'h0 || OUT_TO_FPR !== 1'b0 || IN_READY !== 1'b1)
      begin n_err++; $display("FAIL rst_stall got v%b d%h t%0d f%b r%b want 0 0 0 0 1", OUT_VALID, OUT_DATA, OUT_TAG, OUT_TO_FPR, IN_READY); end
    drive(1, OP_FMV_F, 0, 64'h4000_0000, 7, 1, 0, 0);
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_TAG !== 6'd7 || OUT_DATA !== 64'hFFFF_FFFF_4000_0000)
      begin n_err++; $display("FAIL rst_first got v%b t%0d d%h want 1 7 ffffffff40000000", OUT_VALID, OUT_TAG, OUT_DATA); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
  endtask
  task automatic test_random();
    logic [63:0] src;
    for (int i = 0; i < 600; i++) begin
      src = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        1: src[63:32] = 32'hFFFFFFFF;
        2: begin src[63:32] = 32'hFFFFFFFF; src[30:23] = $urandom_range(0, 1) ? 8'hFF : 8'h00; end
        3: src[62:52] = $urandom_range(0, 1) ? 11'h7FF : 11'h000;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin src[22:0] = '0; src[51:32] = '0; end
      drive($urandom_range(0, 9) < 7, 2'($urandom), 1'($urandom), src, 6'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
      n_cmp++; if (OUT_VALID !== (q.size() > 0)) begin n_err++; $display("FAIL rnd%0d_valid got %b want %b", i, OUT_VALID, q.size() > 0); end
      n_cmp++; if (IN_READY !== (q.size() < 2)) begin n_err++; $display("FAIL rnd%0d_ready got %b want %b", i, IN_READY, q.size() < 2); end
      if (q.size() > 0) begin
        n_cmp++; if ({OUT_DATA, OUT_TAG, OUT_TO_FPR} !== q[0])
          begin n_err++; $display("FAIL rnd%0d_out got %h/%0d/%b want %h/%0d/%b", i, OUT_DATA, OUT_TAG, OUT_TO_FPR, q[0].data, q[0].tag, q[0].fpr); end
      end
    end
  endtask
  initial begin
    @(negedge CLK);
    test_reset();
    test_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
